// File: rtl/bmem_responder.sv
// Memory-side end of the bmem interface: a synthesizable 256-bit line store that
// accepts 4-beat line writes and answers line reads as in-order 4-beat bursts.
module bmem_responder #(
  parameter int READ_LATENCY = 8,
  parameter int QDEPTH       = 4,
  parameter int MEM_LINES    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        proto_err
);

  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LW = $clog2(MEM_LINES);
  localparam logic [QW:0] Q_FULL = QDEPTH[QW:0];
  localparam logic [15:0] ISSUE_AGE = 16'(READ_LATENCY - 1);

  localparam logic W_IDLE  = 1'b0;
  localparam logic W_BURST = 1'b1;

  logic [255:0] mem [MEM_LINES];
  logic [26:0]  q_line [QDEPTH];
  logic [15:0]  q_ts [QDEPTH];

  logic [15:0]  ts;
  logic [QW-1:0] wptr;
  logic [QW-1:0] rptr;
  logic [QW:0]  count;
  logic         ready_en;
  logic         wstate;
  logic [1:0]   wbeat;
  logic [26:0]  waddr;
  logic [1:0]   rbeat;
  logic [255:0] line_buf;

  logic         push;
  logic         pop;
  logic         wr_start;
  logic         wr_beat;
  logic         engine_free;
  logic [15:0]  age;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^bmem_addr[4:0];

  // A burst in progress is never back-pressured; otherwise a full read queue stalls everyone.
  assign bmem_ready  = ready_en && ((wstate == W_BURST) || (count != Q_FULL));
  assign push        = bmem_ready && bmem_read && !bmem_write && (wstate == W_IDLE);
  assign wr_start    = bmem_ready && bmem_write && !bmem_read && (wstate == W_IDLE);
  assign wr_beat     = (wstate == W_BURST) && bmem_write;
  assign age         = ts - q_ts[rptr];
  assign engine_free = !bmem_rvalid || (rbeat == 2'd3);
  assign pop         = (count != '0) && (age >= ISSUE_AGE) && engine_free;
  assign bmem_rdata  = line_buf[{rbeat, 6'd0} +: 64];

  always_ff @(posedge clk) begin
    if (wr_start) begin
      mem[bmem_addr[5 +: LW]][63:0] <= bmem_wdata;
    end else if (wr_beat) begin
      mem[waddr[LW-1:0]][{wbeat, 6'd0} +: 64] <= bmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_line[wptr] <= bmem_addr[31:5];
      q_ts[wptr]   <= ts;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts          <= '0;
      ready_en    <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      wstate      <= W_IDLE;
      wbeat       <= 2'd0;
      waddr       <= '0;
      rbeat       <= 2'd0;
      line_buf    <= '0;
      bmem_rvalid <= 1'b0;
      bmem_raddr  <= '0;
      proto_err   <= 1'b0;
    end else begin
      ts       <= ts + 16'd1;
      ready_en <= 1'b1;

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Line data is captured at issue so writes committed before then are visible.
      if (pop) begin
        bmem_rvalid <= 1'b1;
        rbeat       <= 2'd0;
        bmem_raddr  <= {q_line[rptr], 5'b0};
        line_buf    <= mem[q_line[rptr][LW-1:0]];
      end else if (bmem_rvalid) begin
        rbeat <= rbeat + 2'd1;
        if (rbeat == 2'd3) bmem_rvalid <= 1'b0;
      end

      if (wstate == W_IDLE) begin
        if (wr_start) begin
          waddr  <= bmem_addr[31:5];
          wbeat  <= 2'd1;
          wstate <= W_BURST;
        end
      end else if (bmem_write) begin
        wbeat <= wbeat + 2'd1;
        if (wbeat == 2'd3) wstate <= W_IDLE;
      end

      if (bmem_ready && ((bmem_read && bmem_write) ||
                         ((wstate == W_BURST) && bmem_read) ||
                         (wr_beat && (bmem_addr[31:5] != waddr)))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: expected read beats (cycle, address, data)
// are queued when a read is accepted and checked by an independent monitor.
module tb_bmem_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        proto_err;

  typedef struct {
    int          cyc;
    logic [31:0] raddr;
    logic [63:0] data;
  } beat_t;

  beat_t        sb[$];
  logic [255:0] model [256];
  int           cyc;
  int           next_free;
  int           errors;
  int           checks;

  bmem_responder #(.READ_LATENCY(8), .QDEPTH(4), .MEM_LINES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .proto_err  (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Monitor: every rvalid beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && bmem_rvalid) begin
      if (sb.size() == 0) begin
        timeoutFail("unexpected_beat");
      end else begin
        beat_t e;
        e = sb.pop_front();
        checkOutput("beat_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("beat_raddr", 64'(bmem_raddr), 64'(e.raddr));
        checkOutput("beat_rdata", bmem_rdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [255:0] line,
                         input int stall_beat, input int stall_n, input int rd_beat);
    bit ok;
    ok = 0;
    bmem_addr  = addr;
    bmem_write = 1'b1;
    bmem_read  = 1'b0;
    bmem_wdata = line[63:0];
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bmem_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (!ok) timeoutFail("write_accept");
    for (int b = 1; b < 4; b++) begin
      if (b == stall_beat) begin
        bmem_write = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          checkOutput("stall_ready", 64'(bmem_ready), 64'd1);
          @(posedge clk);
          #1;
        end
      end
      bmem_write = 1'b1;
      bmem_read  = (b == rd_beat);
      bmem_wdata = line[b*64 +: 64];
      @(posedge clk);
      #1;
    end
    bmem_write = 1'b0;
    bmem_read  = 1'b0;
    model[addr[12:5]] = line;
  endtask

  task automatic doRead(input logic [31:0] addr, output logic first_ready, output int acc);
    int first;
    acc         = -1;
    first_ready = 1'b0;
    bmem_addr   = addr;
    bmem_read   = 1'b1;
    bmem_write  = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n == 0) first_ready = bmem_ready;
      if (bmem_ready) begin
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      timeoutFail("read_accept");
    end else begin
      first = (acc + 8 > next_free) ? acc + 8 : next_free;
      next_free = first + 4;
      for (int k = 0; k < 4; k++)
        sb.push_back('{first + k, {addr[31:5], 5'b0}, model[addr[12:5]][k*64 +: 64]});
    end
    @(posedge clk);
    #1;
    bmem_read = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400; n++) begin
      if (sb.size() == 0) begin
        idle(3);
        return;
      end
      idle(1);
    end
    timeoutFail("drain");
    sb.delete();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    next_free = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic applyStimulus();
    logic fr;
    int   acc;
    int   acc1;
    int   acc5;
    int   beats_after;

    // Reset values.
    rst_n = 1'b1;
    bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_ready",  64'(bmem_ready), 64'd0);
    checkOutput("reset_rvalid", 64'(bmem_rvalid), 64'd0);
    checkOutput("reset_raddr",  64'(bmem_raddr), 64'd0);
    checkOutput("reset_rdata",  bmem_rdata, 64'd0);
    checkOutput("reset_proto",  64'(proto_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("ready_before_edge", 64'(bmem_ready), 64'd0);
    @(posedge clk);
    #1 checkOutput("ready_after_edge", 64'(bmem_ready), 64'd1);

    // Single write then read.
    doWrite(32'h40, {64'h4444444444444444, 64'h3333333333333333,
                     64'h2222222222222222, 64'h1111111111111111}, -1, 0, -1);
    idle(2);
    doRead(32'h40, fr, acc);
    drain();

    // Queue fill.
    doWrite(32'h00, {64'hA003, 64'hA002, 64'hA001, 64'hA000}, -1, 0, -1);
    doWrite(32'h20, {64'hB003, 64'hB002, 64'hB001, 64'hB000}, -1, 0, -1);
    doWrite(32'h60, {64'hC003, 64'hC002, 64'hC001, 64'hC000}, -1, 0, -1);
    doWrite(32'h80, {64'hD003, 64'hD002, 64'hD001, 64'hD000}, -1, 0, -1);
    idle(1);
    doRead(32'h00, fr, acc1);
    doRead(32'h20, fr, acc);
    doRead(32'h40, fr, acc);
    doRead(32'h60, fr, acc);
    doRead(32'h80, fr, acc5);
    checkOutput("full_ready", 64'(fr), 64'd0);
    checkOutput("ready_after_pop", 64'(acc5), 64'(acc1 + 8));
    drain();

    // Write stall between beats 1 and 2.
    doWrite(32'hC0, {64'hE0E0E0E0E0E0E0E3, 64'hE0E0E0E0E0E0E0E2,
                     64'hE0E0E0E0E0E0E0E1, 64'hE0E0E0E0E0E0E0E0}, 2, 3, -1);
    @(negedge clk);
    checkOutput("stall_proto", 64'(proto_err), 64'd0);
    @(posedge clk);
    #1;
    doRead(32'hC0, fr, acc);
    drain();

    // Address aliasing: both map to line index 2.
    doWrite(32'h1000_0040, {64'h5555000000000003, 64'h5555000000000002,
                            64'h5555000000000001, 64'h5555000000000000}, -1, 0, -1);
    idle(1);
    doRead(32'h0000_2040, fr, acc);
    drain();

    // Read and write together: dropped, flag set and sticky.
    bmem_addr = 32'h60; bmem_read = 1'b1; bmem_write = 1'b1; bmem_wdata = 64'hDEAD;
    @(posedge clk);
    #1;
    bmem_read = 1'b0; bmem_write = 1'b0;
    @(negedge clk);
    checkOutput("proto_both", 64'(proto_err), 64'd1);
    idle(5);
    @(negedge clk);
    checkOutput("proto_sticky", 64'(proto_err), 64'd1);
    @(posedge clk);
    #1;
    doRead(32'h60, fr, acc);
    drain();

    // Read during a write burst.
    doReset();
    checkOutput("proto_cleared", 64'(proto_err), 64'd0);
    doWrite(32'hA0, {64'h7777000000000003, 64'h7777000000000002,
                     64'h7777000000000001, 64'h7777000000000000}, -1, 0, 1);
    @(negedge clk);
    checkOutput("proto_rd_in_burst", 64'(proto_err), 64'd1);
    @(posedge clk);
    #1;
    doRead(32'hA0, fr, acc);
    drain();

    // Async reset during beat 2 of a burst.
    doRead(32'h40, fr, acc);
    while (cyc < acc + 10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("beat2_rvalid", 64'(bmem_rvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_rvalid", 64'(bmem_rvalid), 64'd0);
    checkOutput("reset_drops_ready", 64'(bmem_ready), 64'd0);
    sb.delete();
    next_free = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("release_ready_low", 64'(bmem_ready), 64'd0);
    @(posedge clk);
    #1 checkOutput("release_ready_high", 64'(bmem_ready), 64'd1);
    beats_after = 0;
    repeat (20) begin
      @(negedge clk);
      if (bmem_rvalid) beats_after++;
    end
    checkOutput("beats_after_reset", 64'(beats_after), 64'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    next_free = 0;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
